// File: rtl/aemb_ifetch_fifo.sv
// ---------------------------------------------------------------------------
// aemb_ifetch_fifo
// Instruction fetch unit with a prefetch FIFO. Owns the fetch PC, drives a
// classic Wishbone instruction port with one outstanding request, buffers up
// to 2**DEPTH_LOG2 words and presents the head word to decode. Taken branches
// flush the buffer and redirect fetch. Interrupts are injected as an opcode
// at legal boundaries, meaning never in a branch delay slot or after IMM.
//
// Optional feature (macro AEMB_IFETCH_BYPASS_EN):
//   When defined, a word acknowledged while the FIFO is empty goes straight
//   to xIREG in the same cycle (zero ack->issue latency). When undefined,
//   every word passes through the FIFO (one cycle latency).
//
// Ports:
//   gclk, grst           clock, synchronous active-high reset
//   gena                 decode consumes xIREG this cycle
//   brn_i, brn_adr_i     taken branch and its target word address
//   rMSR_IE, sys_int_i   interrupt enable and level interrupt request
//   iwb_stb_o/adr_o      fetch strobe and word address (held until ack)
//   iwb_ack_i/dat_i      fetch acknowledge and instruction data
//   xIREG, xVLD          instruction to decode and its valid flag
//   rLVL                 FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module aemb_ifetch_fifo #(
   parameter int              DEPTH_LOG2 = 2,
   parameter int              AW         = 30,
   parameter logic [AW-1:0]   RESET_ADR  = '0
) (
   input  logic                  gclk,
   input  logic                  grst,
   input  logic                  gena,
   input  logic                  brn_i,
   input  logic [AW-1:0]         brn_adr_i,
   input  logic                  rMSR_IE,
   input  logic                  sys_int_i,
   output logic                  iwb_stb_o,
   output logic [AW-1:0]         iwb_adr_o,
   input  logic                  iwb_ack_i,
   input  logic [31:0]           iwb_dat_i,
   output logic [31:0]           xIREG,
   output logic                  xVLD,
   output logic [DEPTH_LOG2:0]   rLVL
);

   localparam int                  DEPTH  = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL   = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [31:0]         OP_NOP = 32'h8800_0000;
   localparam logic [31:0]         OP_INT = 32'hB9CE_0010;

   // Opcodes after which the next slot is not a legal interrupt boundary:
   // IMM prefixes the next word, the branches own a delay slot.
   function automatic logic isGuarded(input logic [5:0] op);
      return op inside {6'o54, 6'o55, 6'o46, 6'o56, 6'o47, 6'o57};
   endfunction

   logic [31:0]           rMem [DEPTH];
   logic [DEPTH_LOG2-1:0] rRd, rWr;
   logic                  rStb;
   logic [AW-1:0]         rAdr;
   logic [AW-1:0]         rTgt;    // redirect target while a dropped ack is outstanding
   logic                  rDrop;   // the outstanding fetch belongs to a flushed stream
   logic                  rINTP;
   logic [5:0]            rOpc;    // opcode of the last issued instruction

   logic                  ackV;
   logic                  fifoVld;
   logic                  inject;
   logic                  byp;
   logic                  consume;
   logic                  pop;
   logic                  push;
   logic [DEPTH_LOG2:0]   lvlNext;

   assign iwb_stb_o = rStb;
   assign iwb_adr_o = rAdr;

   assign ackV    = rStb & iwb_ack_i;
   assign fifoVld = (rLVL != '0);
   assign inject  = rINTP & gena & ~isGuarded(rOpc);

`ifdef AEMB_IFETCH_BYPASS_EN
   // A dropped ack never reaches decode, and a flush suppresses the bypass.
   assign byp = ~fifoVld & ~brn_i & ackV & ~rDrop;
`else
   assign byp = 1'b0;
`endif

   // NOTE: every output of a combinational block gets a default at the top,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      xIREG = OP_NOP;
      xVLD  = 1'b0;
      if (inject) begin
         xIREG = OP_INT;
         xVLD  = 1'b1;
      end else if (fifoVld) begin
         xIREG = rMem[rRd];
         xVLD  = 1'b1;
      end else if (byp) begin
         xIREG = iwb_dat_i;
         xVLD  = 1'b1;
      end
   end

   // An injected opcode does not consume the FIFO head; a flush overrides
   // both push and pop. A bypassed word that decode takes is never stored.
   assign consume = gena & xVLD & ~inject & ~brn_i;
   assign pop     = consume & fifoVld;
   assign push    = ackV & ~rDrop & ~brn_i & ~(byp & consume);
   assign lvlNext = rLVL + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);

   // NOTE: the storage array carries no reset; occupancy and pointers alone
   // decide which entries are meaningful, so stale contents are never seen.
   always_ff @(posedge gclk) begin
      if (push) rMem[rWr] <= iwb_dat_i;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge gclk) begin
      if (grst) begin
         rStb  <= 1'b0;
         rAdr  <= RESET_ADR;
         rTgt  <= RESET_ADR;
         rDrop <= 1'b0;
         rINTP <= 1'b0;
         rOpc  <= '0;
         rLVL  <= '0;
         rRd   <= '0;
         rWr   <= '0;
      end else begin
         // Interrupt latch: survives flushes, dropped when interrupts are disabled.
         if (!rMSR_IE)       rINTP <= 1'b0;
         else if (inject)    rINTP <= 1'b0;
         else if (sys_int_i) rINTP <= 1'b1;

         if (brn_i) begin
            rLVL <= '0;
            rRd  <= '0;
            rWr  <= '0;
            rOpc <= '0;
            if (rStb && !iwb_ack_i) begin
               // A strobe cannot be withdrawn: let it complete, discard its
               // data and redirect afterwards.
               rDrop <= 1'b1;
               rTgt  <= brn_adr_i;
            end else begin
               rDrop <= 1'b0;
               rAdr  <= brn_adr_i;
               rStb  <= 1'b1;
            end
         end else begin
            if (gena && xVLD) rOpc <= xIREG[31:26];
            if (push)         rWr  <= rWr + DEPTH_LOG2'(1);
            if (pop)          rRd  <= rRd + DEPTH_LOG2'(1);
            rLVL <= lvlNext;

            // A new request is raised only while the buffer, counted after
            // this cycle's push/pop, still has room for the returning word.
            if (ackV) begin
               rAdr  <= rDrop ? rTgt : rAdr + AW'(1);
               rDrop <= 1'b0;
               rStb  <= (lvlNext < FULL);
            end else if (!rStb) begin
               rStb  <= (lvlNext < FULL);
            end
         end
      end
   end

endmodule

// File: tb/tb_aemb_ifetch_fifo.sv
// ---------------------------------------------------------------------------
// tb_aemb_ifetch_fifo
// Directed bench for aemb_ifetch_fifo. A combinational Wishbone slave returns
// a word derived from the address; a scoreboard queue receives the expected
// word for every accepted fetch and is popped whenever decode takes a real
// instruction. Occupancy is compared against the queue depth every cycle.
// ---------------------------------------------------------------------------
module tb_aemb_ifetch_fifo;

   localparam logic [31:0] OP_NOP = 32'h8800_0000;
   localparam logic [31:0] OP_INT = 32'hB9CE_0010;

   logic        gclk = 1'b0;
   logic        grst;
   logic        gena;
   logic        brn_i;
   logic [29:0] brn_adr_i;
   logic        rMSR_IE;
   logic        sys_int_i;
   logic        iwb_stb_o;
   logic [29:0] iwb_adr_o;
   logic        iwb_ack_i;
   logic [31:0] iwb_dat_i;
   logic [31:0] xIREG;
   logic        xVLD;
   logic [2:0]  rLVL;

   logic        ackEn;

   int          nChecks = 0;
   int          nPass   = 0;
   int          nFail   = 0;

   logic [31:0] q[$];
   logic [29:0] expFetch;
   logic        dropping;
   int          maxLvl;

   always #5 gclk = ~gclk;

   // Memory image: 0x200 holds an IMM prefix, everything else an ADDI-class
   // word tagged with its own address.
   function automatic logic [31:0] dataFor(input logic [29:0] a);
      if (a == 30'h200) return {6'o54, 10'd0, 16'h1234};
      return {6'o10, a[25:0]};
   endfunction

   assign iwb_ack_i = ackEn & iwb_stb_o;
   assign iwb_dat_i = dataFor(iwb_adr_o);

   aemb_ifetch_fifo dut (
      .gclk      (gclk),
      .grst      (grst),
      .gena      (gena),
      .brn_i     (brn_i),
      .brn_adr_i (brn_adr_i),
      .rMSR_IE   (rMSR_IE),
      .sys_int_i (sys_int_i),
      .iwb_stb_o (iwb_stb_o),
      .iwb_adr_o (iwb_adr_o),
      .iwb_ack_i (iwb_ack_i),
      .iwb_dat_i (iwb_dat_i),
      .xIREG     (xIREG),
      .xVLD      (xVLD),
      .rLVL      (rLVL)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) nPass++;
      else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sample();
      @(negedge gclk);
   endtask

   // Scoreboard update for the current cycle, then advance past the edge.
   task automatic finishCycle();
      if (!grst) begin
         check("lvl_vs_model", 32'(rLVL), 32'(q.size()));
         if (int'(rLVL) > maxLvl) maxLvl = int'(rLVL);
         if (iwb_ack_i && !brn_i) begin
            if (!dropping || iwb_adr_o === expFetch) begin
               if (!dropping) check("fetch_adr", 32'(iwb_adr_o), 32'(expFetch));
               dropping = 1'b0;
               q.push_back(dataFor(expFetch));
               expFetch = expFetch + 30'd1;
            end
         end
         if (gena && xVLD && !brn_i && xIREG !== OP_INT) begin
            check("issue_has_word", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) check("issue_word", xIREG, q.pop_front());
         end
         if (brn_i) begin
            q.delete();
            dropping = 1'b1;
            expFetch = brn_adr_i;
         end
      end
      @(posedge gclk);
      #1;
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         sample();
         finishCycle();
      end
   endtask

   initial begin
      logic [29:0] heldAdr;
      logic [29:0] bypAdr;
      logic        found;

      grst = 1'b1; gena = 1'b0; brn_i = 1'b0; brn_adr_i = '0;
      rMSR_IE = 1'b0; sys_int_i = 1'b0; ackEn = 1'b0;
      expFetch = '0; dropping = 1'b0; maxLvl = 0;

      // Reset state
      repeat (3) @(posedge gclk);
      #1;
      sample();
      check("rst_stb",   32'(iwb_stb_o), 32'd0);
      check("rst_adr",   32'(iwb_adr_o), 32'd0);
      check("rst_lvl",   32'(rLVL),      32'd0);
      check("rst_vld",   32'(xVLD),      32'd0);
      check("rst_ireg",  xIREG,          OP_NOP);
      @(posedge gclk);
      #1;

      // Streaming: ack every cycle, decode always advancing
      grst = 1'b0; gena = 1'b1; ackEn = 1'b1;
      cyc(12);

      // Stall decode: buffer fills to depth and the strobe drops
      gena = 1'b0;
      cyc(8);
      sample();
      check("full_lvl", 32'(rLVL),      32'd4);
      check("full_stb", 32'(iwb_stb_o), 32'd0);
      finishCycle();
      gena = 1'b1;
      cyc(1);
      sample();
      check("refill_stb", 32'(iwb_stb_o), 32'd1);
      finishCycle();
      cyc(6);

      // Branch with a strobe pending and the ack delayed three cycles
      ackEn = 1'b0;
      cyc(3);
      sample();
      check("pend_stb", 32'(iwb_stb_o), 32'd1);
      finishCycle();
      heldAdr   = expFetch;
      brn_i     = 1'b1;
      brn_adr_i = 30'h100;
      cyc(1);
      brn_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample();
         check("drop_hold_adr", 32'(iwb_adr_o), 32'(heldAdr));
         check("drop_hold_stb", 32'(iwb_stb_o), 32'd1);
         check("drop_vld",      32'(xVLD),      32'd0);
         finishCycle();
      end
      ackEn = 1'b1;
      sample();
      check("drop_ack_adr", 32'(iwb_adr_o), 32'(heldAdr));
      check("drop_ack_vld", 32'(xVLD),      32'd0);
      finishCycle();
      sample();
      check("redir_adr", 32'(iwb_adr_o), 32'h100);
      check("redir_stb", 32'(iwb_stb_o), 32'd1);
`ifndef AEMB_IFETCH_BYPASS_EN
      check("redir_vld", 32'(xVLD), 32'd0);
`endif
      finishCycle();
      cyc(4);

      // Interrupt raised right after an IMM issues: deferred by one issue
      rMSR_IE   = 1'b1;
      brn_i     = 1'b1;
      brn_adr_i = 30'h200;
      cyc(1);
      brn_i = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         sample();
         if (xVLD && xIREG[31:26] == 6'o54) found = 1'b1;
         finishCycle();
      end
      check("imm_issued", 32'(found), 32'd1);
      gena = 1'b0; sys_int_i = 1'b1;
      cyc(1);
      sys_int_i = 1'b0;
      cyc(4);
      gena = 1'b1;
      sample();
      check("int_defer_ireg", xIREG, dataFor(30'h201));
      check("int_defer_vld",  32'(xVLD), 32'd1);
      finishCycle();
      sample();
      check("int_inject_ireg", xIREG, OP_INT);
      check("int_inject_vld",  32'(xVLD), 32'd1);
      finishCycle();
      sample();
      check("int_head_kept", xIREG, dataFor(30'h202));
      finishCycle();
      rMSR_IE = 1'b0;
      cyc(2);

      // Branch coincident with ack and decode advance
      for (int i = 0; i < 10 && !iwb_stb_o; i++) cyc(1);
      check("bca_stb_pre", 32'(iwb_stb_o), 32'd1);
      brn_i     = 1'b1;
      brn_adr_i = 30'h300;
      sample();
      check("bca_ack", 32'(iwb_ack_i), 32'd1);
      finishCycle();
      brn_i = 1'b0;
      sample();
      check("bca_lvl", 32'(rLVL),      32'd0);
      check("bca_adr", 32'(iwb_adr_o), 32'h300);
      check("bca_stb", 32'(iwb_stb_o), 32'd1);
`ifndef AEMB_IFETCH_BYPASS_EN
      check("bca_vld", 32'(xVLD), 32'd0);
`endif
      finishCycle();
      cyc(4);

      // Ack into an empty FIFO with decode advancing: issue latency
      ackEn = 1'b0;
      cyc(6);
      sample();
      check("lat_empty", 32'(rLVL),      32'd0);
      check("lat_stb",   32'(iwb_stb_o), 32'd1);
      finishCycle();
      ackEn  = 1'b1;
      bypAdr = expFetch;
      sample();
`ifdef AEMB_IFETCH_BYPASS_EN
      check("byp_vld",  32'(xVLD), 32'd1);
      check("byp_ireg", xIREG,     dataFor(bypAdr));
`else
      check("lat_vld0", 32'(xVLD), 32'd0);
`endif
      finishCycle();
      ackEn = 1'b0;
      sample();
`ifdef AEMB_IFETCH_BYPASS_EN
      check("byp_lvl",  32'(rLVL), 32'd0);
      check("byp_vld1", 32'(xVLD), 32'd0);
`else
      check("lat_vld1", 32'(xVLD), 32'd1);
      check("lat_ireg", xIREG,     dataFor(bypAdr));
      check("lat_lvl",  32'(rLVL), 32'd1);
`endif
      finishCycle();
      cyc(2);

      check("lvl_max_le_depth", 32'(maxLvl <= 4), 32'd1);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
